// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - Dilithium modulus constants, coefficient type and Barrett constant helper
package dilithium_pkg;

   localparam int unsigned DIL_Q = 8380417;
   localparam int          DIL_K = $clog2(DIL_Q);

   // MU = floor(2^(2K) / q), kept in 64 bits so any q < 2^31 is exact
   function automatic logic [63:0] barrett_mu(input logic [63:0] q, input int k);
      return (64'd1 << (2 * k)) / q;
   endfunction

   localparam logic [63:0] DIL_MU = barrett_mu(64'(DIL_Q), DIL_K);

   typedef logic [23:0] coeff_t;

endpackage

// File: rtl/modular_mul_pipe_barrett_lane.sv
// rtl/modular_mul_pipe_barrett_lane.sv - one lane of the 3-stage Barrett modular multiplier
// MODMUL_ACC_EN adds addend port a so the lane computes (x*y + a) mod Q.
module barrett_lane
   import dilithium_pkg::*;
#(
   parameter int unsigned Q      = DIL_Q,
   parameter int          DATA_W = $bits(coeff_t),
   parameter int          K      = $clog2(Q)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
`ifdef MODMUL_ACC_EN
   input  logic [DATA_W-1:0] a,
`endif
   output logic [DATA_W-1:0] z
);

   localparam int PW = 2 * K;
   localparam int MW = K + 1;
   localparam int RW = K + 2;
   localparam logic [63:0]   MU64 = barrett_mu(64'(Q), K);
   localparam logic [MW-1:0] MU   = MW'(MU64);
   localparam logic [RW-1:0] Q_R  = RW'(Q);

   logic [2*DATA_W-1:0] xy;
   logic [PW+MW-1:0]    prod;
   logic [PW-1:0]       p1, p2;
   logic [MW-1:0]       qhat, q2;
   logic [RW-1:0]       qq, r0, r1, r2;

`ifdef MODMUL_ACC_EN
   assign xy = (2*DATA_W)'(x) * (2*DATA_W)'(y) + (2*DATA_W)'(a);
`else
   assign xy = (2*DATA_W)'(x) * (2*DATA_W)'(y);
`endif

   assign prod = (PW+MW)'(p1) * (PW+MW)'(MU);
   assign qhat = MW'(prod >> PW);

   // qhat underestimates floor(p/Q) by at most 2, so r < 3Q fits in K+2 bits
   always_comb begin
      qq = RW'(q2) * Q_R;
      r0 = RW'(p2) - qq;
      r1 = (r0 >= Q_R) ? r0 - Q_R : r0;
      r2 = (r1 >= Q_R) ? r1 - Q_R : r1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0;
         p2 <= '0;
         q2 <= '0;
         z  <= '0;
      end else if (en) begin
         p1 <= PW'(xy);
         p2 <= p1;
         q2 <= qhat;
         z  <= DATA_W'(K'(r2));
      end
   end

endmodule

// File: rtl/modular_mul_pipe.sv
// rtl/modular_mul_pipe.sv - pipelined multi-lane modular multiplier z = (x*y) mod Q with tag sideband
// MODMUL_ACC_EN adds per-lane addend a_i and computes z = (x*y + a) mod Q.
module modular_mul_pipe
   import dilithium_pkg::*;
#(
   parameter int unsigned Q      = DIL_Q,
   parameter int          DATA_W = $bits(coeff_t),
   parameter int          LANES  = 1,
   parameter int          TAG_W  = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [LANES-1:0][DATA_W-1:0] x_i,
   input  logic [LANES-1:0][DATA_W-1:0] y_i,
`ifdef MODMUL_ACC_EN
   input  logic [LANES-1:0][DATA_W-1:0] a_i,
`endif
   input  logic [TAG_W-1:0]             tag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [LANES-1:0][DATA_W-1:0] z_o,
   output logic [TAG_W-1:0]             tag_o
);

   localparam int K = $clog2(Q);

   logic             adv;
   logic             v1, v2, v3;
   logic [TAG_W-1:0] tag1, tag2, tag3;

   // Whole pipe freezes only when the output stage holds an undelivered beat
   assign adv         = !v3 || out_ready_i;
   assign in_ready_o  = adv;
   assign out_valid_o = v3;
   assign tag_o       = tag3;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         tag1 <= '0;
         tag2 <= '0;
         tag3 <= '0;
      end else if (adv) begin
         v1   <= in_valid_i;
         v2   <= v1;
         v3   <= v2;
         tag1 <= tag_i;
         tag2 <= tag1;
         tag3 <= tag2;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      barrett_lane #(
         .Q      (Q),
         .DATA_W (DATA_W),
         .K      (K)
      ) u_lane (
         .clk   (clk_i),
         .rst_n (rst_ni),
         .en    (adv),
         .x     (x_i[l]),
         .y     (y_i[l]),
`ifdef MODMUL_ACC_EN
         .a     (a_i[l]),
`endif
         .z     (z_o[l])
      );
   end

endmodule

// File: tb/tb_modular_mul_pipe.sv
// tb/tb_modular_mul_pipe.sv - self-checking bench: reference-model scoreboard plus directed vectors
module tb_modular_mul_pipe;

   localparam int unsigned Q     = 8380417;
   localparam int          DW    = 24;
   localparam int          LANES = 4;
   localparam int          TW    = 8;

   typedef logic [LANES-1:0][DW-1:0] vec_t;
   typedef struct {
      vec_t          z;
      logic [TW-1:0] tag;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   vec_t          x_i = '0, y_i = '0, a_v = '0, z_o;
   logic [TW-1:0] tag_i = '0, tag_o;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;

   int            n_checks = 0;
   int            n_fail = 0;
   int            n_delivered = 0;
   logic [TW-1:0] last_tag = '0;
   logic          rnd_ready = 1'b0;
   beat_t         exp_q[$];

   always #5 clk = ~clk;

   modular_mul_pipe #(
      .Q      (Q),
      .DATA_W (DW),
      .LANES  (LANES),
      .TAG_W  (TW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .x_i         (x_i),
      .y_i         (y_i),
`ifdef MODMUL_ACC_EN
      .a_i         (a_v),
`endif
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .z_o         (z_o),
      .tag_o       (tag_o)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t model(input vec_t x, input vec_t y, input vec_t a);
      vec_t r;
      for (int l = 0; l < LANES; l++) begin
`ifdef MODMUL_ACC_EN
         r[l] = DW'((64'(x[l]) * 64'(y[l]) + 64'(a[l])) % 64'(Q));
`else
         r[l] = DW'((64'(x[l]) * 64'(y[l])) % 64'(Q));
`endif
      end
      return r;
   endfunction

   // Scoreboard: expected beats enter on accept, leave on delivery; stalled outputs must hold
   logic          hold_v = 1'b0;
   vec_t          hold_z;
   logic [TW-1:0] hold_tag;
   always @(negedge clk) begin
      if (!rst_ni) begin
         exp_q.delete();
         chk("rst_valid", 128'(out_valid_o), 128'(0));
         chk("rst_z", 128'(z_o), 128'(0));
         chk("rst_tag", 128'(tag_o), 128'(0));
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            chk("hold_valid", 128'(out_valid_o), 128'(1));
            chk("hold_z", 128'(z_o), 128'(hold_z));
            chk("hold_tag", 128'(tag_o), 128'(hold_tag));
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("stale_beat", 128'(out_valid_o), 128'(0));
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               for (int l = 0; l < LANES; l++)
                  chk($sformatf("z_lane%0d", l), 128'(z_o[l]), 128'(b.z[l]));
               chk("tag", 128'(tag_o), 128'(b.tag));
            end
            n_delivered++;
            last_tag = tag_o;
         end
         if (in_valid_i && in_ready_o)
            exp_q.push_back('{z: model(x_i, y_i, a_v), tag: tag_i});
         hold_v   = out_valid_o && !out_ready_i;
         hold_z   = z_o;
         hold_tag = tag_o;
      end
   end

   task automatic send_beat(input vec_t x, input vec_t y, input vec_t a, input logic [TW-1:0] t);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      x_i = x; y_i = y; a_v = a; tag_i = t; in_valid_i = 1'b1;
      while (!acc && n < 50) begin
         if (rnd_ready) out_ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk); #1;
         n++;
      end
      in_valid_i = 1'b0;
      if (!acc) chk("send_timeout", 128'(acc), 128'(1));
   endtask

   task automatic drain(input int cycles);
      out_ready_i = 1'b1;
      repeat (cycles) begin
         @(posedge clk); #1;
      end
   endtask

   // Single beat into an idle pipe: out_valid_o must rise exactly 3 cycles after accept
   task automatic latency_beat(input vec_t x, input vec_t y, input vec_t a, input vec_t exp_z, input string name);
      out_ready_i = 1'b1;
      x_i = x; y_i = y; a_v = a; tag_i = 8'hA5; in_valid_i = 1'b1;
      @(negedge clk);
      chk({name, "_ready"}, 128'(in_ready_o), 128'(1));
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         chk($sformatf("%s_lat%0d", name, i), 128'(out_valid_o), 128'(i == 3));
         if (i == 3) begin
            for (int l = 0; l < LANES; l++)
               chk($sformatf("%s_lit%0d", name, l), 128'(z_o[l]), 128'(exp_z[l]));
            chk({name, "_tag"}, 128'(tag_o), 128'(8'hA5));
         end
         @(posedge clk); #1;
      end
   endtask

   vec_t vx, vy, va, vz;
   int   base;
   logic [TW-1:0] pat_v [6];
   logic          pat_o [6];

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", 128'(in_ready_o), 128'(1));
      rst_ni = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 128'(in_ready_o), 128'(1));

      // Directed literals
      vx[0] = DW'(8380416); vy[0] = DW'(8380416); vz[0] = DW'(1);
      vx[1] = DW'(2);       vy[1] = DW'(4190209); vz[1] = DW'(1);
      vx[2] = DW'(0);       vy[2] = DW'(12345);   vz[2] = DW'(0);
      vx[3] = DW'(4096);    vy[3] = DW'(4096);    vz[3] = DW'(16382);
      va = '0;
      latency_beat(vx, vy, va, vz, "lit_a");
      vx[0] = DW'(8380416); vy[0] = DW'(2);    vz[0] = DW'(8380415);
      vx[1] = DW'(1234567); vy[1] = DW'(1);    vz[1] = DW'(1234567);
      vx[2] = DW'(1000);    vy[2] = DW'(1000); vz[2] = DW'(1000000);
      vx[3] = DW'(8380416); vy[3] = DW'(1);    vz[3] = DW'(8380416);
      latency_beat(vx, vy, va, vz, "lit_b");
`ifdef MODMUL_ACC_EN
      vx[0] = DW'(8380416); vy[0] = DW'(1);       va[0] = DW'(1);       vz[0] = DW'(0);
      vx[1] = DW'(3);       vy[1] = DW'(5);       va[1] = DW'(8380416); vz[1] = DW'(14);
      vx[2] = DW'(0);       vy[2] = DW'(0);       va[2] = DW'(0);       vz[2] = DW'(0);
      vx[3] = DW'(8380416); vy[3] = DW'(8380416); va[3] = DW'(1);       vz[3] = DW'(2);
      latency_beat(vx, vy, va, vz, "acc");
      va = '0;
`endif

      // Backpressure: three beats fill the pipe, fourth waits while out_ready_i is low
      out_ready_i = 1'b0;
      base = n_delivered;
      for (int t = 1; t <= 3; t++) begin
         for (int l = 0; l < LANES; l++) begin
            vx[l] = DW'(t * 1000 + l); vy[l] = DW'(Q - 1 - t - l);
         end
         send_beat(vx, vy, va, TW'(t));
      end
      x_i = vx; y_i = vy; tag_i = TW'(4); in_valid_i = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("bp_in_ready", 128'(in_ready_o), 128'(0));
         chk("bp_out_valid", 128'(out_valid_o), 128'(1));
         @(posedge clk); #1;
      end
      out_ready_i = 1'b1;
      send_beat(vx, vy, va, TW'(4));
      send_beat(vy, vx, va, TW'(5));
      drain(6);
      chk("bp_count", 128'(n_delivered - base), 128'(5));
      chk("bp_last_tag", 128'(last_tag), 128'(5));

      // Bubbles: valid pattern 1,0,1 reappears 3 cycles later
      pat_v[0] = 1; pat_v[1] = 0; pat_v[2] = 1; pat_v[3] = 0; pat_v[4] = 0; pat_v[5] = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid_i = pat_v[c][0];
         tag_i = TW'(8'h30 + c);
         @(negedge clk);
         pat_o[c] = out_valid_o;
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0;
      for (int c = 0; c < 6; c++)
         chk($sformatf("bubble_%0d", c), 128'(pat_o[c]), 128'(c >= 3 ? pat_v[c-3][0] : 1'b0));
      drain(4);

      // Reset with three beats in flight
      out_ready_i = 1'b0;
      base = n_delivered;
      for (int t = 0; t < 3; t++) send_beat(vx, vy, va, TW'(8'h40 + t));
      #2 rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", 128'(out_valid_o), 128'(0));
      chk("mid_rst_z", 128'(z_o), 128'(0));
      @(posedge clk); #2;
      rst_ni = 1'b1;
      drain(8);
      chk("rst_no_stale", 128'(n_delivered - base), 128'(0));
      latency_beat(vx, vy, va, model(vx, vy, va), "post_rst");

      // Random traffic with random backpressure and boundary operands mixed in
      rnd_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         for (int l = 0; l < LANES; l++) begin
            case ($urandom_range(0, 7))
               0:       vx[l] = DW'(Q - 1);
               1:       vx[l] = '0;
               default: vx[l] = DW'($urandom_range(0, Q - 1));
            endcase
            vy[l] = ($urandom_range(0, 7) == 0) ? DW'(Q - 1) : DW'($urandom_range(0, Q - 1));
`ifdef MODMUL_ACC_EN
            va[l] = DW'($urandom_range(0, Q - 1));
`endif
         end
         send_beat(vx, vy, va, TW'(i));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rnd_ready = 1'b0;
      drain(10);
      chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
      chk("final_out_valid", 128'(out_valid_o), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
